// File: rtl/bank_pkg.sv
// Shared opcode encoding and address-layout constants for the bank hit test unit.
package bank_pkg;

   typedef enum logic [1:0] {
      HTU_READ  = 2'd0,
      HTU_WRITE = 2'd1,
      HTU_FLUSH = 2'd2,
      HTU_NOP   = 2'd3
   } htu_op_e;

   localparam int HALF_OFF_BIT = 4;
   localparam int LINE_OFF_W   = 5;

endpackage

// File: rtl/bank_htu_set_ways.sv
// One cache set: WAYS lines of {valid, tag, dirty halves} plus a round-robin replacement pointer.
module bank_htu_set_ways
   import bank_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int TAG_W = 22,
   parameter int WAY_W = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              upd_i,
   input  htu_op_e           op_i,
   input  logic              offset_i,
   input  logic [TAG_W-1:0]  tag_i,
   output logic [WAYS-1:0]   hit_vec_o,
   output logic [WAY_W-1:0]  sel_way_o,
   output logic              sel_valid_o,
   output logic [TAG_W-1:0]  sel_tag_o,
   output logic [1:0]        sel_dirty_o
);

   logic [WAYS-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0] tag_q   [WAYS];
   logic [TAG_W-1:0] tag_d   [WAYS];
   logic [1:0]       dirty_q [WAYS];
   logic [1:0]       dirty_d [WAYS];
   logic [WAY_W-1:0] rr_q, rr_d;

   logic             hit;
   logic             any_inv;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] sel_way;
   logic [1:0]       off_mask;

   // Descending scan so the lowest-index invalid way wins.
   always_comb begin
      hit_vec_o = '0;
      hit_way   = '0;
      inv_way   = '0;
      any_inv   = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit_vec_o[w] = valid_q[w] && (tag_q[w] == tag_i);
         if (hit_vec_o[w]) hit_way = WAY_W'(w);
         if (!valid_q[w]) begin
            any_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
      hit     = |hit_vec_o;
      sel_way = hit ? hit_way : (any_inv ? inv_way : rr_q);
   end

   assign off_mask    = offset_i ? 2'b10 : 2'b01;
   assign sel_way_o   = sel_way;
   assign sel_valid_o = valid_q[sel_way];
   assign sel_tag_o   = tag_q[sel_way];
   assign sel_dirty_o = dirty_q[sel_way];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      dirty_d = dirty_q;
      rr_d    = rr_q;
      if (upd_i) begin
         case (op_i)
            HTU_READ, HTU_WRITE: begin
               if (hit) begin
                  if (op_i == HTU_WRITE) dirty_d[sel_way] = dirty_q[sel_way] | off_mask;
               end else begin
                  valid_d[sel_way] = 1'b1;
                  tag_d[sel_way]   = tag_i;
                  dirty_d[sel_way] = (op_i == HTU_WRITE) ? off_mask : 2'b00;
                  // Pointer only advances when a valid line was displaced.
                  if (!any_inv) rr_d = rr_q + WAY_W'(1);
               end
            end
            HTU_FLUSH: begin
               if (hit) begin
                  valid_d[sel_way] = 1'b0;
                  dirty_d[sel_way] = 2'b00;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         rr_q    <= '0;
         for (int w = 0; w < WAYS; w++) dirty_q[w] <= 2'b00;
      end else begin
         valid_q <= valid_d;
         rr_q    <= rr_d;
         dirty_q <= dirty_d;
      end
   end

   // Tags are qualified by valid, so they need no reset.
   always_ff @(posedge clk_i) begin
      tag_q <= tag_d;
   end

endmodule

// File: rtl/bank_htu_assoc.sv
// Set-associative hit test unit for one cache bank: lookup, allocate-on-miss, registered result.
module bank_htu_assoc
   import bank_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int SET_W  = 3,
   parameter int BANK_W = 2,
   parameter int WAYS   = 2,
   parameter int CH_W   = 2,
   parameter int WBUF_W = 8,
   localparam int NUM_SETS = 2 ** SET_W,
   localparam int WAY_W    = $clog2(WAYS),
   localparam int TAG_W    = ADDR_W - 5 - SET_W - BANK_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              xbar_bank_htu_valid_i,
   output logic              xbar_bank_htu_ready_o,
   input  logic [CH_W-1:0]   xbar_bank_htu_ch_id_i,
   input  logic [1:0]        xbar_bank_htu_opcode_i,
   input  logic [ADDR_W-5:0] xbar_bank_htu_addr_i,
   input  logic [WBUF_W-1:0] xbar_bank_htu_wbuffer_id_i,
   output logic              htu_rsp_valid_o,
   input  logic              htu_rsp_ready_i,
   output logic [CH_W-1:0]   htu_rsp_ch_id_o,
   output logic [1:0]        htu_rsp_opcode_o,
   output logic [WBUF_W-1:0] htu_rsp_wbuffer_id_o,
   output logic [SET_W-1:0]  htu_rsp_set_o,
   output logic              htu_rsp_offset_o,
   output logic              htu_rsp_hit_o,
   output logic [WAY_W-1:0]  htu_rsp_way_o,
   output logic              htu_rsp_victim_valid_o,
   output logic [TAG_W-1:0]  htu_rsp_victim_tag_o,
   output logic [1:0]        htu_rsp_victim_dirty_o
);

   // The address port starts at bit 4, so every field index is shifted down by 4.
   logic [SET_W-1:0]  set_idx;
   logic              offset;
   logic [TAG_W-1:0]  tag;
   logic [BANK_W-1:0] unused_bank_bits;
   htu_op_e           op;
   logic              fire;

   assign offset           = xbar_bank_htu_addr_i[HALF_OFF_BIT - 4];
   assign set_idx          = xbar_bank_htu_addr_i[LINE_OFF_W - 4 +: SET_W];
   assign unused_bank_bits = xbar_bank_htu_addr_i[LINE_OFF_W - 4 + SET_W +: BANK_W];
   assign tag              = xbar_bank_htu_addr_i[ADDR_W - 5 -: TAG_W];
   assign op               = htu_op_e'(xbar_bank_htu_opcode_i);

   assign xbar_bank_htu_ready_o = !htu_rsp_valid_o || htu_rsp_ready_i;
   assign fire                  = xbar_bank_htu_valid_i && xbar_bank_htu_ready_o;

   logic [WAYS-1:0]  set_hit_vec   [NUM_SETS];
   logic [WAY_W-1:0] set_sel_way   [NUM_SETS];
   logic             set_sel_valid [NUM_SETS];
   logic [TAG_W-1:0] set_sel_tag   [NUM_SETS];
   logic [1:0]       set_sel_dirty [NUM_SETS];

   for (genvar g = 0; g < NUM_SETS; g++) begin : g_set
      bank_htu_set_ways #(
         .WAYS  (WAYS),
         .TAG_W (TAG_W),
         .WAY_W (WAY_W)
      ) u_set (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .upd_i       (fire && (set_idx == SET_W'(g))),
         .op_i        (op),
         .offset_i    (offset),
         .tag_i       (tag),
         .hit_vec_o   (set_hit_vec[g]),
         .sel_way_o   (set_sel_way[g]),
         .sel_valid_o (set_sel_valid[g]),
         .sel_tag_o   (set_sel_tag[g]),
         .sel_dirty_o (set_sel_dirty[g])
      );
   end

   logic             hit_d;
   logic [WAY_W-1:0] way_d;
   logic             vic_valid_d;
   logic [TAG_W-1:0] vic_tag_d;
   logic [1:0]       vic_dirty_d;
   logic             rsp_valid_d;

   // Victim fields are forced to zero when no line is displaced.
   always_comb begin
      hit_d       = 1'b0;
      way_d       = '0;
      vic_valid_d = 1'b0;
      vic_tag_d   = '0;
      vic_dirty_d = 2'b00;
      case (op)
         HTU_READ, HTU_WRITE: begin
            hit_d       = |set_hit_vec[set_idx];
            way_d       = set_sel_way[set_idx];
            vic_valid_d = !hit_d && set_sel_valid[set_idx];
         end
         HTU_FLUSH: begin
            hit_d       = |set_hit_vec[set_idx];
            way_d       = set_sel_way[set_idx];
            vic_valid_d = hit_d;
         end
         default: ;
      endcase
      if (vic_valid_d) begin
         vic_tag_d   = set_sel_tag[set_idx];
         vic_dirty_d = set_sel_dirty[set_idx];
      end
   end

   assign rsp_valid_d = fire ? 1'b1 : (htu_rsp_ready_i ? 1'b0 : htu_rsp_valid_o);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         htu_rsp_valid_o        <= 1'b0;
         htu_rsp_ch_id_o        <= '0;
         htu_rsp_opcode_o       <= '0;
         htu_rsp_wbuffer_id_o   <= '0;
         htu_rsp_set_o          <= '0;
         htu_rsp_offset_o       <= 1'b0;
         htu_rsp_hit_o          <= 1'b0;
         htu_rsp_way_o          <= '0;
         htu_rsp_victim_valid_o <= 1'b0;
         htu_rsp_victim_tag_o   <= '0;
         htu_rsp_victim_dirty_o <= 2'b00;
      end else begin
         htu_rsp_valid_o <= rsp_valid_d;
         if (fire) begin
            htu_rsp_ch_id_o        <= xbar_bank_htu_ch_id_i;
            htu_rsp_opcode_o       <= xbar_bank_htu_opcode_i;
            htu_rsp_wbuffer_id_o   <= xbar_bank_htu_wbuffer_id_i;
            htu_rsp_set_o          <= set_idx;
            htu_rsp_offset_o       <= offset;
            htu_rsp_hit_o          <= hit_d;
            htu_rsp_way_o          <= way_d;
            htu_rsp_victim_valid_o <= vic_valid_d;
            htu_rsp_victim_tag_o   <= vic_tag_d;
            htu_rsp_victim_dirty_o <= vic_dirty_d;
         end
      end
   end

endmodule

// File: tb/tb_bank_htu_assoc.sv
// Directed and randomized bench for bank_htu_assoc against an array-based cache model.
module tb_bank_htu_assoc;

   localparam int ADDR_W = 32;
   localparam int SET_W  = 3;
   localparam int BANK_W = 2;
   localparam int WAYS   = 2;
   localparam int CH_W   = 2;
   localparam int WBUF_W = 8;
   localparam int TAG_W  = 22;
   localparam int NSETS  = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [CH_W-1:0]   req_ch;
   logic [1:0]        req_op;
   logic [ADDR_W-5:0] req_addr;
   logic [WBUF_W-1:0] req_wb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [CH_W-1:0]   rsp_ch;
   logic [1:0]        rsp_op;
   logic [WBUF_W-1:0] rsp_wb;
   logic [SET_W-1:0]  rsp_set;
   logic              rsp_off;
   logic              rsp_hit;
   logic              rsp_way;
   logic              rsp_vv;
   logic [TAG_W-1:0]  rsp_vtag;
   logic [1:0]        rsp_vd;

   bank_htu_assoc #(
      .ADDR_W (ADDR_W), .SET_W (SET_W), .BANK_W (BANK_W),
      .WAYS (WAYS), .CH_W (CH_W), .WBUF_W (WBUF_W)
   ) dut (
      .clk_i                      (clk),
      .rst_i                      (rst_n),
      .xbar_bank_htu_valid_i      (req_valid),
      .xbar_bank_htu_ready_o      (req_ready),
      .xbar_bank_htu_ch_id_i      (req_ch),
      .xbar_bank_htu_opcode_i     (req_op),
      .xbar_bank_htu_addr_i       (req_addr),
      .xbar_bank_htu_wbuffer_id_i (req_wb),
      .htu_rsp_valid_o            (rsp_valid),
      .htu_rsp_ready_i            (rsp_ready),
      .htu_rsp_ch_id_o            (rsp_ch),
      .htu_rsp_opcode_o           (rsp_op),
      .htu_rsp_wbuffer_id_o       (rsp_wb),
      .htu_rsp_set_o              (rsp_set),
      .htu_rsp_offset_o           (rsp_off),
      .htu_rsp_hit_o              (rsp_hit),
      .htu_rsp_way_o              (rsp_way),
      .htu_rsp_victim_valid_o     (rsp_vv),
      .htu_rsp_victim_tag_o       (rsp_vtag),
      .htu_rsp_victim_dirty_o     (rsp_vd)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference cache state: one entry per (set, way).
   bit          m_valid [NSETS][WAYS];
   int unsigned m_tag   [NSETS][WAYS];
   int unsigned m_dirty [NSETS][WAYS];
   int          m_rr    [NSETS];

   int unsigned e_hit, e_way, e_vv, e_vtag, e_vd;
   int unsigned e_ch, e_op, e_wb, e_set, e_off;
   bit          e_way_known;

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", nm, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NSETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_tag[s][w]   = 0;
            m_dirty[s][w] = 0;
         end
      end
   endtask

   task automatic model_step(input int op, input int unsigned tag, input int set, input int off);
      int h;
      int inv;
      h = -1;
      inv = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[set][w] && m_tag[set][w] == tag) h = w;
      e_hit = 0; e_way = 0; e_vv = 0; e_vtag = 0; e_vd = 0; e_way_known = 1'b1;
      if (op == 0 || op == 1) begin
         if (h >= 0) begin
            e_hit = 1;
            e_way = h;
            if (op == 1) m_dirty[set][h] = m_dirty[set][h] | (1 << off);
         end else begin
            for (int w = 0; w < WAYS; w++)
               if (!m_valid[set][w] && inv < 0) inv = w;
            if (inv >= 0) e_way = inv;
            else begin
               e_way  = m_rr[set];
               e_vv   = 1;
               e_vtag = m_tag[set][e_way];
               e_vd   = m_dirty[set][e_way];
               m_rr[set] = (m_rr[set] + 1) % WAYS;
            end
            m_valid[set][e_way] = 1'b1;
            m_tag[set][e_way]   = tag;
            m_dirty[set][e_way] = (op == 1) ? (1 << off) : 0;
         end
      end else if (op == 2) begin
         if (h >= 0) begin
            e_hit  = 1;
            e_way  = h;
            e_vv   = 1;
            e_vtag = m_tag[set][h];
            e_vd   = m_dirty[set][h];
            m_valid[set][h] = 1'b0;
            m_dirty[set][h] = 0;
         end else e_way_known = 1'b0;
      end
   endtask

   task automatic drive(input int op, input int unsigned tag, input int set, input int off);
      logic [21:0] t;
      logic [1:0]  b;
      logic [2:0]  s;
      t = tag[21:0];
      b = 2'($urandom_range(0, 3));
      s = set[2:0];
      req_ch    = CH_W'($urandom_range(0, 3));
      req_wb    = WBUF_W'($urandom_range(0, 255));
      req_op    = op[1:0];
      req_addr  = {t, b, s, off[0]};
      req_valid = 1'b1;
      e_ch = req_ch; e_wb = req_wb; e_op = op; e_set = set; e_off = off;
   endtask

   task automatic check_rsp(input string nm);
      chk({nm, "_valid"}, rsp_valid, 1);
      chk({nm, "_ch"}, rsp_ch, e_ch);
      chk({nm, "_op"}, rsp_op, e_op);
      chk({nm, "_wb"}, rsp_wb, e_wb);
      chk({nm, "_set"}, rsp_set, e_set);
      chk({nm, "_off"}, rsp_off, e_off);
      chk({nm, "_hit"}, rsp_hit, e_hit);
      if (e_way_known) chk({nm, "_way"}, rsp_way, e_way);
      chk({nm, "_vv"}, rsp_vv, e_vv);
      if (e_vv != 0) begin
         chk({nm, "_vtag"}, rsp_vtag, e_vtag);
         chk({nm, "_vd"}, rsp_vd, e_vd);
      end
   endtask

   // Called just after a clock edge; the request fires on the next edge.
   task automatic do_req(input string nm, input int op, input int unsigned tag, input int set, input int off);
      drive(op, tag, set, off);
      #1;
      chk({nm, "_ready"}, req_ready, 1);
      model_step(op, tag, set, off);
      @(posedge clk);
      #1;
      check_rsp(nm);
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a_hit, a_way, a_op, a_wb, a_ch;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_ch = '0; req_op = '0; req_addr = '0; req_wb = '0;
      rsp_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", rsp_valid, 0);
      chk("rst_hit", rsp_hit, 0);
      chk("rst_way", rsp_way, 0);
      chk("rst_vv", rsp_vv, 0);
      chk("rst_vtag", rsp_vtag, 0);
      chk("rst_ch", rsp_ch, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 1);

      // Cold miss then hit on the same line.
      do_req("rd_miss", 0, 1, 0, 0);
      chk("rd_miss_hit_c", rsp_hit, 0);
      do_req("rd_hit", 0, 1, 0, 0);
      chk("rd_hit_hit_c", rsp_hit, 1);

      // Dirty upper half, flush reports it, then the line is gone.
      do_req("wr_hit", 1, 1, 0, 1);
      do_req("flush", 2, 1, 0, 1);
      chk("flush_vd_c", rsp_vd, 2'b10);
      chk("flush_vtag_c", rsp_vtag, 1);
      do_req("rd_after_flush", 0, 1, 0, 0);
      chk("rd_after_flush_hit_c", rsp_hit, 0);

      // Round-robin replacement in set 3.
      do_req("fill1", 0, 1, 3, 0);
      do_req("fill2", 0, 2, 3, 0);
      do_req("evict1", 0, 3, 3, 0);
      chk("evict1_vtag_c", rsp_vtag, 1);
      chk("evict1_way_c", rsp_way, 0);
      do_req("evict2", 0, 4, 3, 0);
      chk("evict2_vtag_c", rsp_vtag, 2);
      chk("evict2_way_c", rsp_way, 1);
      idle();
      chk("idle_valid", rsp_valid, 0);

      // Backpressure: result A held while B waits.
      do_req("bp_a", 0, 5, 1, 0);
      a_hit = e_hit; a_way = e_way; a_op = e_op; a_wb = e_wb; a_ch = e_ch;
      rsp_ready = 1'b0;
      drive(1, 5, 1, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_ready", req_ready, 0);
         chk("bp_valid", rsp_valid, 1);
         chk("bp_hit", rsp_hit, a_hit);
         chk("bp_way", rsp_way, a_way);
         chk("bp_op", rsp_op, a_op);
         chk("bp_wb", rsp_wb, a_wb);
         chk("bp_ch", rsp_ch, a_ch);
      end
      model_step(1, 5, 1, 1);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_rsp("bp_b");
      idle();
      chk("bp_drain", rsp_valid, 0);
      do_req("bp_after", 0, 5, 1, 1);

      // Back-to-back random stream.
      for (int i = 0; i < 16; i++)
         do_req("rand", $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      idle();

      // Reset mid-stream discards state and the pending result.
      do_req("pre_rst_a", 0, 7, 2, 0);
      do_req("pre_rst_b", 0, 7, 2, 0);
      chk("pre_rst_hit_c", rsp_hit, 1);
      #2;
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_ready", req_ready, 1);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_req("post_rst", 0, 7, 2, 0);
      chk("post_rst_hit_c", rsp_hit, 0);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
